// File: rtl/pin_change_irq.sv
// ---------------------------------------------------------------------------
// pin_change_irq
//
// Watches a bank of already-synchronized port pins. It raises two kinds of
// interrupt:
//   - a pin-change interrupt (pcif / pcint_irq) when any pin selected by
//     the mask changes value, and
//   - an external interrupt on pin 0 (intf0 / int0_irq). Its sense
//     (level, any edge, falling edge or rising edge) is chosen by isc.
//
// Parameters
//   p_width        number of monitored pins
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst            synchronous, active-high reset
//   d_sync         pin values, already synchronized to clk
//   pcmsk_we/wdata write strobe and data for the pin-change mask
//   pcie_we/wdata  write strobe and data for the pin-change interrupt enable
//   isc_we/wdata   write strobe and data for the INT0 sense control
//   int0_en_we/wdata write strobe and data for the INT0 enable
//   pcif_clr       write-one-to-clear strobe for pcif
//   intf0_clr      write-one-to-clear strobe for intf0
//   pcint_ack      interrupt acknowledge; clears pcif
//   int0_ack       interrupt acknowledge; clears intf0 (edge modes only)
//   pcmsk, pcie, isc, int0_en   register readback
//   pcif, intf0    pending flags
//   pcint_irq      pcif & pcie
//   int0_irq       intf0 & int0_en in edge modes;
//                  int0_en & ~d_sync[0] in low-level mode
// ---------------------------------------------------------------------------
module pin_change_irq #(
   parameter int p_width = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [p_width-1:0] d_sync,
   input  logic               pcmsk_we,
   input  logic [p_width-1:0] pcmsk_wdata,
   input  logic               pcie_we,
   input  logic               pcie_wdata,
   input  logic               isc_we,
   input  logic [1:0]         isc_wdata,
   input  logic               int0_en_we,
   input  logic               int0_en_wdata,
   input  logic               pcif_clr,
   input  logic               intf0_clr,
   input  logic               pcint_ack,
   input  logic               int0_ack,
   output logic [p_width-1:0] pcmsk,
   output logic               pcie,
   output logic [1:0]         isc,
   output logic               int0_en,
   output logic               pcif,
   output logic               intf0,
   output logic               pcint_irq,
   output logic               int0_irq
);

   typedef enum logic [1:0] {
      SENSE_LOW  = 2'b00,
      SENSE_ANY  = 2'b01,
      SENSE_FALL = 2'b10,
      SENSE_RISE = 2'b11
   } sense_t;

   logic [p_width-1:0] d_prev_reg;
   logic               armed_reg;
   logic [p_width-1:0] pcmsk_reg,   pcmsk_next;
   logic               pcie_reg,    pcie_next;
   sense_t             isc_reg,     isc_next;
   logic               int0_en_reg, int0_en_next;
   logic               pcif_reg,    pcif_next;
   logic               intf0_reg,   intf0_next;

   logic [p_width-1:0] chg;
   logic               pc_hit;
   logic               int0_hit;
   logic               pin0_rise;
   logic               pin0_fall;

   // Per-pin change detect. The mask used here is the registered value, so a
   // change in the same cycle as a mask write is judged against the old mask.
   genvar gi;
   generate
      for (gi = 0; gi < p_width; gi++) begin : g_chg
         assign chg[gi] = (d_sync[gi] ^ d_prev_reg[gi]) & pcmsk_reg[gi];
      end
   endgenerate

   // armed stays low for the first cycle after reset. A pin that differs
   // across the reset boundary therefore never counts as a change.
   assign pc_hit    = armed_reg & (|chg);
   assign pin0_rise = ~d_prev_reg[0] &  d_sync[0];
   assign pin0_fall =  d_prev_reg[0] & ~d_sync[0];

   always_comb begin
      int0_hit = 1'b0;
      case (isc_reg)
         SENSE_ANY:  int0_hit = armed_reg & (pin0_rise | pin0_fall);
         SENSE_FALL: int0_hit = armed_reg & pin0_fall;
         SENSE_RISE: int0_hit = armed_reg & pin0_rise;
         default:    int0_hit = 1'b0;
      endcase
   end

   always_comb begin
      pcmsk_next   = pcmsk_reg;
      pcie_next    = pcie_reg;
      isc_next     = isc_reg;
      int0_en_next = int0_en_reg;
      pcif_next    = pcif_reg;
      intf0_next   = intf0_reg;

      if (pcmsk_we)   pcmsk_next   = pcmsk_wdata;
      if (pcie_we)    pcie_next    = pcie_wdata;
      if (isc_we)     isc_next     = sense_t'(isc_wdata);
      if (int0_en_we) int0_en_next = int0_en_wdata;

      // A set wins over a clear in the same cycle.
      if (pc_hit)
         pcif_next = 1'b1;
      else if (pcif_clr || pcint_ack)
         pcif_next = 1'b0;

      // In low-level mode the flag is not used and is held at zero.
      if (isc_reg == SENSE_LOW)
         intf0_next = 1'b0;
      else if (int0_hit)
         intf0_next = 1'b1;
      else if (intf0_clr || int0_ack)
         intf0_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      // d_prev tracks the pins even in reset so that no stale value is
      // compared after reset releases.
      d_prev_reg <= d_sync;
      if (rst) begin
         armed_reg   <= 1'b0;
         pcmsk_reg   <= '0;
         pcie_reg    <= 1'b0;
         isc_reg     <= SENSE_LOW;
         int0_en_reg <= 1'b0;
         pcif_reg    <= 1'b0;
         intf0_reg   <= 1'b0;
      end else begin
         armed_reg   <= 1'b1;
         pcmsk_reg   <= pcmsk_next;
         pcie_reg    <= pcie_next;
         isc_reg     <= isc_next;
         int0_en_reg <= int0_en_next;
         pcif_reg    <= pcif_next;
         intf0_reg   <= intf0_next;
      end
   end

   assign pcmsk     = pcmsk_reg;
   assign pcie      = pcie_reg;
   assign isc       = isc_reg;
   assign int0_en   = int0_en_reg;
   assign pcif      = pcif_reg;
   assign intf0     = intf0_reg;
   assign pcint_irq = pcif_reg & pcie_reg;

   // Low-level mode follows the pin directly, with no flag and no latch.
   assign int0_irq  = (isc_reg == SENSE_LOW) ? (int0_en_reg & ~d_sync[0])
                                             : (intf0_reg & int0_en_reg);

endmodule

// File: tb/tb_pin_change_irq.sv
// ---------------------------------------------------------------------------
// tb_pin_change_irq
//
// Scoreboard bench for pin_change_irq. The stimulus process drives inputs on
// the falling edge. It advances a behavioural model of the block and pushes
// the expected post-edge outputs into a queue. A monitor pops one entry
// shortly after each rising edge and compares every output against it.
// The bench runs directed scenarios first and then randomized traffic.
// ---------------------------------------------------------------------------
module tb_pin_change_irq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] d_sync;
   logic         pcmsk_we;
   logic [W-1:0] pcmsk_wdata;
   logic         pcie_we, pcie_wdata;
   logic         isc_we;
   logic [1:0]   isc_wdata;
   logic         int0_en_we, int0_en_wdata;
   logic         pcif_clr, intf0_clr, pcint_ack, int0_ack;
   logic [W-1:0] pcmsk;
   logic         pcie;
   logic [1:0]   isc;
   logic         int0_en, pcif, intf0, pcint_irq, int0_irq;

   pin_change_irq #(.p_width(W)) dut (
      .clk(clk), .rst(rst), .d_sync(d_sync),
      .pcmsk_we(pcmsk_we), .pcmsk_wdata(pcmsk_wdata),
      .pcie_we(pcie_we), .pcie_wdata(pcie_wdata),
      .isc_we(isc_we), .isc_wdata(isc_wdata),
      .int0_en_we(int0_en_we), .int0_en_wdata(int0_en_wdata),
      .pcif_clr(pcif_clr), .intf0_clr(intf0_clr),
      .pcint_ack(pcint_ack), .int0_ack(int0_ack),
      .pcmsk(pcmsk), .pcie(pcie), .isc(isc), .int0_en(int0_en),
      .pcif(pcif), .intf0(intf0), .pcint_irq(pcint_irq), .int0_irq(int0_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] pcmsk;
      logic         pcie;
      logic [1:0]   isc;
      logic         int0_en, pcif, intf0, pcint_irq, int0_irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Behavioural model state
   logic [W-1:0] m_pcmsk, m_prev;
   logic         m_pcie, m_int0_en, m_pcif, m_intf0, m_armed;
   logic [1:0]   m_isc;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      if (act !== req) begin
         n_err++;
         $display("FAIL %s vec %0d: got %0h, expected %0h", name, n_vec, act, req);
      end
   endtask

   // Monitor: one expected entry per rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk("pcmsk",     pcmsk,            e.pcmsk);
            chk("pcie",      W'(pcie),         W'(e.pcie));
            chk("isc",       W'(isc),          W'(e.isc));
            chk("int0_en",   W'(int0_en),      W'(e.int0_en));
            chk("pcif",      W'(pcif),         W'(e.pcif));
            chk("intf0",     W'(intf0),        W'(e.intf0));
            chk("pcint_irq", W'(pcint_irq),    W'(e.pcint_irq));
            chk("int0_irq",  W'(int0_irq),     W'(e.int0_irq));
         end
      end
   end

   // Applies this cycle's inputs to the model and queues the result
   // expected after the coming rising edge.
   task automatic cyc_end();
      exp_t e;
      logic pin_changed, old0, new0, edge_ok, clr_pc, clr_i0;
      if (rst) begin
         m_pcmsk = '0; m_pcie = 0; m_isc = 0; m_int0_en = 0;
         m_pcif = 0; m_intf0 = 0; m_armed = 0;
      end else begin
         pin_changed = m_armed && (((d_sync ^ m_prev) & m_pcmsk) != 0);
         old0 = m_prev[0];
         new0 = d_sync[0];
         case (m_isc)
            2'd1:    edge_ok = (old0 != new0);
            2'd2:    edge_ok = (old0 == 1'b1) && (new0 == 1'b0);
            2'd3:    edge_ok = (old0 == 1'b0) && (new0 == 1'b1);
            default: edge_ok = 1'b0;
         endcase
         edge_ok = edge_ok && m_armed;
         clr_pc = pcif_clr || pcint_ack;
         clr_i0 = intf0_clr || int0_ack;
         if (pin_changed)  m_pcif = 1;
         else if (clr_pc)  m_pcif = 0;
         if (m_isc == 2'd0) m_intf0 = 0;
         else if (edge_ok)  m_intf0 = 1;
         else if (clr_i0)   m_intf0 = 0;
         if (pcmsk_we)   m_pcmsk   = pcmsk_wdata;
         if (pcie_we)    m_pcie    = pcie_wdata;
         if (isc_we)     m_isc     = isc_wdata;
         if (int0_en_we) m_int0_en = int0_en_wdata;
         m_armed = 1;
      end
      m_prev = d_sync;
      e.pcmsk     = m_pcmsk;
      e.pcie      = m_pcie;
      e.isc       = m_isc;
      e.int0_en   = m_int0_en;
      e.pcif      = m_pcif;
      e.intf0     = m_intf0;
      e.pcint_irq = m_pcif && m_pcie;
      e.int0_irq  = (m_isc == 2'd0) ? (m_int0_en && !d_sync[0]) : (m_intf0 && m_int0_en);
      exp_q.push_back(e);
   endtask

   task automatic cyc_begin();
      @(negedge clk);
      rst = 0;
      pcmsk_we = 0; pcie_we = 0; isc_we = 0; int0_en_we = 0;
      pcif_clr = 0; intf0_clr = 0; pcint_ack = 0; int0_ack = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_begin();
         cyc_end();
      end
   endtask

   initial begin
      rst = 1; d_sync = 8'hFF;
      pcmsk_we = 0; pcmsk_wdata = 0; pcie_we = 0; pcie_wdata = 0;
      isc_we = 0; isc_wdata = 0; int0_en_we = 0; int0_en_wdata = 0;
      pcif_clr = 0; intf0_clr = 0; pcint_ack = 0; int0_ack = 0;

      // Reset with all pins high
      for (int i = 0; i < 2; i++) begin
         cyc_begin(); rst = 1; d_sync = 8'hFF; cyc_end();
      end

      // Pins drop across the reset boundary while the mask opens: no flag.
      cyc_begin(); d_sync = 8'h00; pcmsk_we = 1; pcmsk_wdata = 8'hFF; cyc_end();
      idle(1);
      cyc_begin(); d_sync = 8'h01; cyc_end();
      idle(1);
      cyc_begin(); pcif_clr = 1; cyc_end();

      // Masked change on pin 2, then acknowledge
      cyc_begin(); pcmsk_we = 1; pcmsk_wdata = 8'h04; pcie_we = 1; pcie_wdata = 1; cyc_end();
      cyc_begin(); d_sync = d_sync ^ 8'h04; cyc_end();
      cyc_begin(); pcint_ack = 1; cyc_end();
      idle(1);

      // Unmasked pin 3 is ignored; with pcie off the flag still sets.
      cyc_begin(); d_sync = d_sync ^ 8'h08; cyc_end();
      cyc_begin(); pcie_we = 1; pcie_wdata = 0; cyc_end();
      cyc_begin(); d_sync = d_sync ^ 8'h04; cyc_end();
      idle(1);

      // Clear together with a new masked change: set wins.
      cyc_begin(); pcif_clr = 1; d_sync = d_sync ^ 8'h04; cyc_end();
      cyc_begin(); pcif_clr = 1; cyc_end();

      // INT0 falling-edge sense, then low-level sense
      cyc_begin(); isc_we = 1; isc_wdata = 2'b10; int0_en_we = 1; int0_en_wdata = 1;
                   d_sync[0] = 1'b1; cyc_end();
      idle(1);
      cyc_begin(); d_sync[0] = 1'b0; cyc_end();
      cyc_begin(); int0_ack = 1; cyc_end();
      cyc_begin(); d_sync[0] = 1'b1; cyc_end();
      idle(1);
      cyc_begin(); isc_we = 1; isc_wdata = 2'b00; cyc_end();
      cyc_begin(); d_sync[0] = 1'b0; cyc_end();
      cyc_begin(); int0_ack = 1; cyc_end();
      cyc_begin(); d_sync[0] = 1'b1; cyc_end();

      // Both flags pending, then reset mid-operation
      cyc_begin(); isc_we = 1; isc_wdata = 2'b11; pcmsk_we = 1; pcmsk_wdata = 8'hFF;
                   pcie_we = 1; pcie_wdata = 1; d_sync[0] = 1'b0; cyc_end();
      cyc_begin(); d_sync[0] = 1'b1; cyc_end();
      idle(1);
      cyc_begin(); rst = 1; pcmsk_we = 1; pcmsk_wdata = 8'h55; pcif_clr = 0;
                   d_sync = 8'hA5; cyc_end();
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc_begin();
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 1) == 1)
            d_sync = d_sync ^ W'($urandom_range(0, 255)) & W'($urandom_range(0, 255));
         pcmsk_we      = ($urandom_range(0, 7) == 0);
         pcmsk_wdata   = W'($urandom_range(0, 255));
         pcie_we       = ($urandom_range(0, 7) == 0);
         pcie_wdata    = 1'($urandom_range(0, 1));
         isc_we        = ($urandom_range(0, 7) == 0);
         isc_wdata     = 2'($urandom_range(0, 3));
         int0_en_we    = ($urandom_range(0, 7) == 0);
         int0_en_wdata = 1'($urandom_range(0, 1));
         pcif_clr      = ($urandom_range(0, 5) == 0);
         intf0_clr     = ($urandom_range(0, 5) == 0);
         pcint_ack     = ($urandom_range(0, 5) == 0);
         int0_ack      = ($urandom_range(0, 5) == 0);
         cyc_end();
      end
      idle(1);

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
